bin_act_expander: RTL and testbench

BIN_ACT_EXPANDER -- requirements
Module: bin_act_expander

---
 rtl/bin_act_expander_pkg.sv | 26 ++
 rtl/bin_act_expander_shifter.sv | 38 +++
 rtl/bin_act_expander.sv | 85 ++++++++
 tb/tb_bin_act_expander.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bin_act_expander_pkg.sv
// rtl/bin_act_expander_pkg.sv - shared types and constants for the binary activation expander (honours BIN_ACT_BIPOLAR_EN)
package bin_act_expander_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_w(input int pw);
    return $clog2(pw + 1);
  endfunction

  function automatic int one_code(input int frac);
    return 1 << frac;
  endfunction

  // A cleared activation bit maps to -ONE in bipolar builds, otherwise to 0.
  function automatic int zero_code(input int frac);
`ifdef BIN_ACT_BIPOLAR_EN
    return -(1 << frac);
`else
    return (frac < 0) ? 1 : 0;
`endif
  endfunction

endpackage

// File: rtl/bin_act_expander_shifter.sv
// rtl/bin_act_expander_shifter.sv - shift register, remaining-bit counter and frame tlast register
module bin_act_shifter #(
  parameter int PW = 16,
  parameter int CW = 5
) (
  input  logic          i_sclk,
  input  logic          i_rstn,
  input  logic          load,
  input  logic          shift,
  input  logic [PW-2:0] load_bits,
  input  logic [CW-1:0] load_cnt,
  input  logic          load_last,
  output logic          next_bit,
  output logic [CW-1:0] rem,
  output logic          frame_last
);

  // Bit 0 of a word is presented straight from the input on load, so only bits 1.. are stored.
  logic [PW-2:0] sreg;

  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      sreg       <= '0;
      rem        <= '0;
      frame_last <= 1'b0;
    end else if (load) begin
      sreg       <= load_bits;
      rem        <= load_cnt;
      frame_last <= load_last;
    end else if (shift) begin
      sreg       <= sreg >> 1;
      rem        <= rem - CW'(1);
    end
  end

  assign next_bit = sreg[0];

endmodule

// File: rtl/bin_act_expander.sv
// rtl/bin_act_expander.sv - expands packed binary activations into fixed-point samples (BIN_ACT_BIPOLAR_EN selects -ONE for 0 bits)
module bin_act_expander
  import bin_act_expander_pkg::*;
#(
  parameter int PW   = 16,
  parameter int WO   = 16,
  parameter int FRAC = 8
) (
  input  logic                      i_sclk,
  input  logic                      i_rstn,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [PW-1:0]             i_tdata,
  input  logic [$clog2(PW+1)-1:0]   i_tcnt,
  input  logic                      i_tlast,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic signed [WO-1:0]      o_tdata,
  output logic                      o_tlast
);

  localparam int CW = cnt_w(PW);
  localparam logic [CW-1:0] PW_CNT = CW'(PW);
  localparam logic signed [WO-1:0] ONE  = WO'(one_code(FRAC));
  localparam logic signed [WO-1:0] ZERO = WO'(zero_code(FRAC));

  state_t        state, state_next;
  logic          load, shift, rem_one;
  logic          next_bit, frame_last;
  logic [CW-1:0] rem, tcnt_eff;

  assign tcnt_eff = (i_tcnt == '0 || i_tcnt > PW_CNT) ? PW_CNT : i_tcnt;
  assign rem_one  = (rem == CW'(1));
  assign load     = i_valid && o_ready;
  assign shift    = o_valid && i_ready && !rem_one;

  always_ff @(posedge i_sclk) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_valid    = 1'b0;
    o_ready    = 1'b0;
    o_tlast    = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_next = SHIFT;
      end
      SHIFT: begin
        o_valid = 1'b1;
        o_ready = rem_one && i_ready;
        o_tlast = frame_last && rem_one;
        // Last bit leaving with no replacement word arriving ends the word.
        if (rem_one && i_ready && !i_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_sclk) begin
    if (!i_rstn)    o_tdata <= '0;
    else if (load)  o_tdata <= i_tdata[0] ? ONE : ZERO;
    else if (shift) o_tdata <= next_bit ? ONE : ZERO;
  end

  bin_act_shifter #(
    .PW (PW),
    .CW (CW)
  ) u_shifter (
    .i_sclk     (i_sclk),
    .i_rstn     (i_rstn),
    .load       (load),
    .shift      (shift),
    .load_bits  (i_tdata[PW-1:1]),
    .load_cnt   (tcnt_eff),
    .load_last  (i_tlast),
    .next_bit   (next_bit),
    .rem        (rem),
    .frame_last (frame_last)
  );

endmodule

// File: tb/tb_bin_act_expander.sv
// tb/tb_bin_act_expander.sv - directed self-checking bench for bin_act_expander
module tb_bin_act_expander;

`ifdef BIN_ACT_BIPOLAR_EN
  localparam int ZV = -256;
`else
  localparam int ZV = 0;
`endif

  logic               i_sclk = 1'b0;
  logic               i_rstn = 1'b0;
  logic               i_valid = 1'b0;
  logic               o_ready;
  logic [15:0]        i_tdata = '0;
  logic [4:0]         i_tcnt = '0;
  logic               i_tlast = 1'b0;
  logic               o_valid;
  logic               i_ready = 1'b0;
  logic signed [15:0] o_tdata;
  logic               o_tlast;

  int checks = 0;
  int failures = 0;

  bin_act_expander dut (
    .i_sclk  (i_sclk),
    .i_rstn  (i_rstn),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_tdata (i_tdata),
    .i_tcnt  (i_tcnt),
    .i_tlast (i_tlast),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_tdata (o_tdata),
    .o_tlast (o_tlast)
  );

  initial forever #5 i_sclk = ~i_sclk;

  task automatic tick();
    @(posedge i_sclk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input string tag, input int data, input int last);
    chk({tag, "_valid"}, int'(o_valid), 1);
    chk({tag, "_data"}, int'(o_tdata), data);
    chk({tag, "_last"}, int'(o_tlast), last);
  endtask

  task automatic send(input logic [15:0] d, input logic [4:0] c, input logic l);
    i_tdata = d; i_tcnt = c; i_tlast = l; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_last", int'(o_tlast), 0);
    chk("rst_data", int'(o_tdata), 0);
    i_rstn = 1'b1; i_ready = 1'b1;
    tick();

    // 0x0005, four bits, end of frame
    send(16'h0005, 5'd4, 1'b1);
    sample("w5_b0", 256, 0); tick();
    sample("w5_b1", ZV, 0);  tick();
    sample("w5_b2", 256, 0); tick();
    sample("w5_b3", ZV, 1);  tick();
    chk("w5_idle_valid", int'(o_valid), 0);
    chk("w5_idle_ready", int'(o_ready), 1);

    // back-to-back 0xFFFF then 0x0000, both tcnt=0
    send(16'hFFFF, 5'd0, 1'b0);
    i_tdata = 16'h0000; i_tcnt = 5'd0; i_tlast = 1'b1; i_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 16) i_valid = 1'b0;
      sample("b2b", (i < 16) ? 256 : ZV, (i == 31) ? 1 : 0);
      if (i == 15) chk("b2b_ready_at_boundary", int'(o_ready), 1);
      tick();
    end
    chk("b2b_idle_valid", int'(o_valid), 0);

    // back-pressure on the second bit of 0x0006
    send(16'h0006, 5'd4, 1'b1);
    sample("bp_b0", ZV, 0); tick();
    i_ready = 1'b0;
    sample("bp_b1", 256, 0);
    chk("bp_ready", int'(o_ready), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      sample("bp_hold", 256, 0);
      chk("bp_hold_ready", int'(o_ready), 0);
    end
    i_ready = 1'b1;
    tick();
    sample("bp_b2", 256, 0);
    tick();
    sample("bp_b3", ZV, 1);
    chk("bp_last_ready", int'(o_ready), 1);
    tick();
    chk("bp_idle_valid", int'(o_valid), 0);

    // tcnt above PW clamps to 16 bits
    send(16'h8001, 5'd20, 1'b1);
    for (int i = 0; i < 16; i++) begin
      sample("tc20", (i == 0 || i == 15) ? 256 : ZV, (i == 15) ? 1 : 0);
      tick();
    end
    chk("tc20_idle_valid", int'(o_valid), 0);

    // bits at or above tcnt are ignored
    send(16'hFFF8, 5'd3, 1'b1);
    sample("tc3_b0", ZV, 0); tick();
    sample("tc3_b1", ZV, 0); tick();
    sample("tc3_b2", ZV, 1); tick();
    chk("tc3_idle_valid", int'(o_valid), 0);

    // reset after the third bit of a 16-bit word
    send(16'hFFFF, 5'd16, 1'b1);
    sample("rw_b0", 256, 0); tick();
    sample("rw_b1", 256, 0); tick();
    sample("rw_b2", 256, 0); tick();
    i_rstn = 1'b0;
    tick();
    chk("rw_valid", int'(o_valid), 0);
    chk("rw_ready", int'(o_ready), 1);
    chk("rw_last", int'(o_tlast), 0);
    chk("rw_data", int'(o_tdata), 0);
    i_rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rw_no_residue", int'(o_valid), 0);
    end

`ifdef BIN_ACT_BIPOLAR_EN
    send(16'h0002, 5'd2, 1'b1);
    sample("bip_b0", -256, 0); tick();
    sample("bip_b1", 256, 1);  tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
